// File: rtl/ifu_pkg.sv
// Shared fetch-stage definitions: bus types, reset PC, NOP encoding and the
// IFU state codes used by ifu and ifu_npc.
package ifu_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] ysyx_23060251_reg_bus;
  typedef logic [31:0]     ysyx_23060251_inst_bus;

  localparam ysyx_23060251_reg_bus  ysyx_23060251_reset_pc = 64'h8000_0000;
  localparam ysyx_23060251_inst_bus ysyx_23060251_nop      = 32'h0000_0013;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // Instructions are 4-byte aligned; any low address bit set is a fetch fault.
  function automatic logic is_misaligned(input ysyx_23060251_reg_bus addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Next-PC selection for the fetch stage: redirect first, then sequential
// advance after an instruction is consumed, otherwise hold.
module ifu_npc
  import ifu_pkg::*;
(
  input  ysyx_23060251_reg_bus pc_i,
  input  logic                 redirect_valid_i,
  input  ysyx_23060251_reg_bus redirect_pc_i,
  input  logic                 advance_i,
  output ysyx_23060251_reg_bus npc_o,
  output logic                 redirect_misaligned_o,
  output logic                 pc_misaligned_o
);

  always_comb begin
    npc_o = pc_i;
    if (redirect_valid_i) begin
      npc_o = redirect_pc_i;
    end else if (advance_i) begin
      npc_o = pc_i + XLEN'(4);
    end
  end

  assign redirect_misaligned_o = redirect_valid_i & is_misaligned(redirect_pc_i);
  assign pc_misaligned_o       = is_misaligned(pc_i);

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// hands each fetched instruction to decode over a valid/ready handshake.
module ifu
  import ifu_pkg::*;
#(
  parameter ysyx_23060251_reg_bus RESET_PC = ysyx_23060251_reset_pc
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  redirect_valid_i,
  input  ysyx_23060251_reg_bus  redirect_pc_i,
  output logic                  imem_req_valid_o,
  output ysyx_23060251_reg_bus  imem_req_addr_o,
  input  logic                  imem_req_ready_i,
  input  logic                  imem_rsp_valid_i,
  input  ysyx_23060251_inst_bus imem_rsp_inst_i,
  input  logic                  imem_rsp_err_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output ysyx_23060251_inst_bus inst_o,
  output ysyx_23060251_reg_bus  pc_o,
  output logic                  fetch_err_o
);

  logic [1:0]            state_q, state_d;
  ysyx_23060251_reg_bus  pc_q, pc_d;
  ysyx_23060251_inst_bus inst_q, inst_d;
  ysyx_23060251_reg_bus  pc_out_q, pc_out_d;
  logic                  err_q, err_d;

  logic                  handshake;
  logic                  redirect_misaligned;
  logic                  pc_misaligned;
  logic                  load_rsp;
  logic                  load_fault;
  ysyx_23060251_reg_bus  fault_pc;

  ifu_npc u_npc (
    .pc_i                  (pc_q),
    .redirect_valid_i      (redirect_valid_i),
    .redirect_pc_i         (redirect_pc_i),
    .advance_i             (handshake),
    .npc_o                 (pc_d),
    .redirect_misaligned_o (redirect_misaligned),
    .pc_misaligned_o       (pc_misaligned)
  );

  // A misaligned PC never reaches memory; it is turned into a fault locally.
  assign imem_req_valid_o = ~rst_i & (state_q == S_REQ) & ~redirect_valid_i & ~pc_misaligned;
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = (state_q == S_HOLD);
  assign handshake        = inst_valid_o & inst_ready_i;

  assign inst_o      = inst_q;
  assign pc_o        = pc_out_q;
  assign fetch_err_o = err_q;

  always_comb begin
    state_d    = state_q;
    load_rsp   = 1'b0;
    load_fault = 1'b0;
    fault_pc   = pc_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid_i) begin
          if (redirect_misaligned) begin
            load_fault = 1'b1;
            fault_pc   = redirect_pc_i;
            state_d    = S_HOLD;
          end
        end else if (pc_misaligned) begin
          load_fault = 1'b1;
          state_d    = S_HOLD;
        end else if (imem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect makes the outstanding response stale; drain it if it is
        // not arriving right now.
        if (redirect_valid_i) begin
          state_d = imem_rsp_valid_i ? S_REQ : S_FLUSH;
        end else if (imem_rsp_valid_i) begin
          load_rsp = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid_i) begin
          if (redirect_misaligned) begin
            load_fault = 1'b1;
            fault_pc   = redirect_pc_i;
            state_d    = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end else if (inst_ready_i) begin
          state_d = S_REQ;
        end
      end
      S_FLUSH: begin
        if (imem_rsp_valid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    err_d    = err_q;
    if (load_rsp) begin
      inst_d   = imem_rsp_err_i ? ysyx_23060251_nop : imem_rsp_inst_i;
      err_d    = imem_rsp_err_i;
      pc_out_d = pc_q;
    end else if (load_fault) begin
      inst_d   = ysyx_23060251_nop;
      err_d    = 1'b1;
      pc_out_d = fault_pc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      pc_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      err_q    <= err_d;
    end
  end

  // Responses are only legal while a request is outstanding.
  assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rsp_valid_i |-> (state_q == S_WAIT || state_q == S_FLUSH));

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a latency-programmable memory model plus a
// scoreboard of instructions that decode is expected to receive.
module tb_ifu;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic [63:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_inst_i = '0;
  logic        imem_rsp_err_i = 1'b0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        fetch_err_o;

  always #5 clk_i = ~clk_i;

  ifu dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_inst_i  (imem_rsp_inst_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .fetch_err_o      (fetch_err_o)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int accept_count = 0;

  int          mem_lat = 2;
  logic        mem_err = 1'b0;
  logic        mem_pending = 1'b0;
  logic [63:0] mem_addr = '0;
  int          mem_cnt = 0;

  function automatic logic [31:0] mem_inst(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0093;
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rdy);
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    inst_ready_i     = rdy;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic waitHandshake(input string tag, output int cycles);
    int start;
    start  = hs_count;
    cycles = 0;
    while (hs_count == start && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput(tag, 64'(hs_count - start), 64'd1);
  endtask

  task automatic waitInstValid(input string tag);
    int n;
    n = 0;
    while (!inst_valid_o && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(inst_valid_o), 64'd1);
  endtask

  // Memory model: accepts at the coming edge, answers mem_lat cycles later.
  always @(negedge clk_i) begin
    imem_rsp_valid_i = 1'b0;
    imem_rsp_inst_i  = 32'hDEAD_BEEF;
    imem_rsp_err_i   = 1'b0;
    if (rst_i) begin
      mem_pending = 1'b0;
    end else begin
      if (mem_pending) begin
        if (mem_cnt == 0) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_inst_i  = mem_inst(mem_addr);
          imem_rsp_err_i   = mem_err;
          mem_pending      = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        mem_pending = 1'b1;
        mem_addr    = imem_req_addr_o;
        mem_cnt     = mem_lat - 1;
        accept_count++;
      end
    end
  end

  // Decode-side monitor: every consumed instruction must match the scoreboard.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && inst_valid_o && inst_ready_i) begin
      hs_count++;
      checkOutput("hs_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("hs_pc", pc_o, e.pc);
        checkOutput("hs_inst", 64'(inst_o), 64'(e.inst));
        checkOutput("hs_err", 64'(fetch_err_o), 64'(e.err));
      end
    end
  end

  initial begin
    int cyc;
    int hs_before;
    int acc_before;

    applyStimulus(1'b0, 64'd0, 1'b0);
    imem_req_ready_i = 1'b1;
    mem_lat = 2;
    repeat (2) @(posedge clk_i);
    #3;
    checkOutput("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    checkOutput("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    checkOutput("rst_inst", 64'(inst_o), 64'd0);
    checkOutput("rst_pc", pc_o, 64'd0);
    checkOutput("rst_err", 64'(fetch_err_o), 64'd0);

    // Reset release and first fetch
    tick();
    rst_i = 1'b0;
    exp_q.push_back('{RESET_PC, 32'h0010_0093, 1'b0});
    applyStimulus(1'b0, 64'd0, 1'b1);
    #1;
    checkOutput("t1_req_valid", 64'(imem_req_valid_o), 64'd1);
    checkOutput("t1_req_addr", imem_req_addr_o, RESET_PC);
    waitHandshake("t1_hs", cyc);
    checkOutput("t1_latency", 64'(cyc), 64'd4);
    checkOutput("t1_next_valid", 64'(imem_req_valid_o), 64'd1);
    checkOutput("t1_next_addr", imem_req_addr_o, RESET_PC + 64'd4);

    // Decode back-pressure
    applyStimulus(1'b0, 64'd0, 1'b0);
    exp_q.push_back('{RESET_PC + 64'd4, mem_inst(RESET_PC + 64'd4), 1'b0});
    waitInstValid("t2_valid");
    acc_before = accept_count;
    hs_before  = hs_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t2_hold_valid", 64'(inst_valid_o), 64'd1);
      checkOutput("t2_hold_inst", 64'(inst_o), 64'(mem_inst(RESET_PC + 64'd4)));
      checkOutput("t2_hold_pc", pc_o, RESET_PC + 64'd4);
      checkOutput("t2_no_req", 64'(imem_req_valid_o), 64'd0);
    end
    checkOutput("t2_no_accept", 64'(accept_count - acc_before), 64'd0);
    imem_req_ready_i = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b1);
    waitHandshake("t2_hs", cyc);
    applyStimulus(1'b0, 64'd0, 1'b0);
    tick();
    tick();
    checkOutput("t2_one_hs", 64'(hs_count - hs_before), 64'd1);
    checkOutput("t2_parked_addr", imem_req_addr_o, RESET_PC + 64'd8);

    // Redirect while a fetch is outstanding
    imem_req_ready_i = 1'b1;
    mem_lat = 3;
    tick();
    checkOutput("t3_wait_req", 64'(imem_req_valid_o), 64'd0);
    exp_q.push_back('{64'h8000_0100, mem_inst(64'h8000_0100), 1'b0});
    applyStimulus(1'b1, 64'h8000_0100, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b1);
    #1;
    checkOutput("t3_flush_req", 64'(imem_req_valid_o), 64'd0);
    checkOutput("t3_flush_valid", 64'(inst_valid_o), 64'd0);
    tick();
    checkOutput("t3_flush_valid2", 64'(inst_valid_o), 64'd0);
    tick();
    checkOutput("t3_req_valid", 64'(imem_req_valid_o), 64'd1);
    checkOutput("t3_req_addr", imem_req_addr_o, 64'h8000_0100);
    waitHandshake("t3_hs", cyc);
    imem_req_ready_i = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0);

    // Redirect in the same cycle as the response
    imem_req_ready_i = 1'b1;
    mem_lat = 2;
    tick();
    tick();
    hs_before = hs_count;
    applyStimulus(1'b1, 64'h8000_0200, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0);
    imem_req_ready_i = 1'b0;
    #1;
    checkOutput("t4_req_valid", 64'(imem_req_valid_o), 64'd1);
    checkOutput("t4_req_addr", imem_req_addr_o, 64'h8000_0200);
    checkOutput("t4_inst_valid", 64'(inst_valid_o), 64'd0);
    tick();
    tick();
    checkOutput("t4_still_idle", 64'(inst_valid_o), 64'd0);
    checkOutput("t4_no_hs", 64'(hs_count - hs_before), 64'd0);

    // Access fault, then a misaligned redirect
    mem_err = 1'b1;
    mem_lat = 1;
    imem_req_ready_i = 1'b1;
    exp_q.push_back('{64'h8000_0200, NOP, 1'b1});
    applyStimulus(1'b0, 64'd0, 1'b1);
    waitHandshake("t5_err_hs", cyc);
    mem_err = 1'b0;
    imem_req_ready_i = 1'b0;
    exp_q.push_back('{64'h8000_0102, NOP, 1'b1});
    applyStimulus(1'b1, 64'h8000_0102, 1'b0);
    #1;
    checkOutput("t5_mis_req", 64'(imem_req_valid_o), 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0);
    #1;
    checkOutput("t5_mis_valid", 64'(inst_valid_o), 64'd1);
    checkOutput("t5_mis_err", 64'(fetch_err_o), 64'd1);
    checkOutput("t5_mis_pc", pc_o, 64'h8000_0102);
    checkOutput("t5_mis_inst", 64'(inst_o), 64'(NOP));
    checkOutput("t5_mis_no_req", 64'(imem_req_valid_o), 64'd0);
    hs_before = hs_count;
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0);
    #1;
    checkOutput("t5_redir_hs", 64'(hs_count - hs_before), 64'd1);
    checkOutput("t5_redir_valid", 64'(imem_req_valid_o), 64'd1);
    checkOutput("t5_redir_addr", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);

    // PC wrap, then reset while a fetch is outstanding
    exp_q.push_back('{64'hFFFF_FFFF_FFFF_FFFC, mem_inst(64'hFFFF_FFFF_FFFF_FFFC), 1'b0});
    imem_req_ready_i = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b1);
    waitHandshake("t6_hs", cyc);
    applyStimulus(1'b0, 64'd0, 1'b0);
    mem_lat = 3;
    checkOutput("t6_wrap_valid", 64'(imem_req_valid_o), 64'd1);
    checkOutput("t6_wrap_addr", imem_req_addr_o, 64'd0);
    tick();
    rst_i = 1'b1;
    #1;
    checkOutput("t6_rst_req", 64'(imem_req_valid_o), 64'd0);
    checkOutput("t6_rst_valid", 64'(inst_valid_o), 64'd0);
    checkOutput("t6_rst_inst", 64'(inst_o), 64'd0);
    checkOutput("t6_rst_pc", pc_o, 64'd0);
    checkOutput("t6_rst_err", 64'(fetch_err_o), 64'd0);
    tick();
    rst_i = 1'b0;
    imem_req_ready_i = 1'b0;
    #1;
    checkOutput("t6_rel_valid", 64'(imem_req_valid_o), 64'd1);
    checkOutput("t6_rel_addr", imem_req_addr_o, RESET_PC);
    tick();
    tick();
    checkOutput("t6_rel_idle", 64'(inst_valid_o), 64'd0);

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
